hls_mul_share_sched: RTL and testbench

//  Resource-constrained scheduler for the four-product HLS kernel (i=a*b, j=c*d, k=e*f, l=g*h).

---
 rtl/hls_sched_pkg.sv | 19 +
 rtl/shared_mul_pipe.sv | 57 +++++
 rtl/hls_mul_share_sched.sv | 129 ++++++++++++
 tb/tb_hls_mul_share_sched.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_sched_pkg.sv
// Shared types and constants for the four-product scheduler that
// time-multiplexes one pipelined multiplier.
package hls_sched_pkg;

  localparam int DW_DEF  = 16;
  localparam int NUM_OPS = 4;

  // Tag carried alongside each product through the multiplier pipeline.
  typedef logic [1:0] op_idx_t;

  localparam op_idx_t LAST_OP = op_idx_t'(NUM_OPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

endpackage

// File: rtl/shared_mul_pipe.sv
// MUL_LAT-stage signed multiplier with a valid/tag shift register alongside.
// The product leaves the pipe MUL_LAT edges after it was issued.
module shared_mul_pipe
  import hls_sched_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int MUL_LAT = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_vld,
  input  op_idx_t              in_tag,
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] y,
  output logic                 out_vld,
  output op_idx_t              out_tag,
  output logic signed [DW-1:0] p
);

  logic [MUL_LAT-1:0]   vld_q;
  op_idx_t              tag_q  [MUL_LAT];
  logic signed [DW-1:0] prod_q [MUL_LAT];
  logic signed [DW-1:0] prod_lo;

  // The low DW bits of a product depend only on the low DW bits of the
  // operands, so evaluating in a DW-wide context is exactly the truncation.
  assign prod_lo = x * y;

  // Valid bits: the only pipeline state that must be cleared by reset.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments let each stage sample the previous
    // stage's pre-edge value, which is what makes this a shift register.
    if (Rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_vld;
      for (int s = 1; s < MUL_LAT; s++) vld_q[s] <= vld_q[s-1];
    end
  end

  // Product and tag stages advance every cycle alongside the valids.
  always_ff @(posedge Clk) begin
    // NOTE: data stages carry no reset; a cleared valid bit makes their
    // contents don't-care, so resetting them would only add reset fan-out.
    tag_q[0]  <= in_tag;
    prod_q[0] <= prod_lo;
    for (int s = 1; s < MUL_LAT; s++) begin
      tag_q[s]  <= tag_q[s-1];
      prod_q[s] <= prod_q[s-1];
    end
  end

  assign out_vld = vld_q[MUL_LAT-1];
  assign out_tag = tag_q[MUL_LAT-1];
  assign p       = prod_q[MUL_LAT-1];

endmodule

// File: rtl/hls_mul_share_sched.sv
// Four-product kernel (i=a*b, j=c*d, k=e*f, l=g*h) scheduled onto a single
// shared pipelined multiplier, keeping the Start/Done handshake of the
// fully parallel kernel. MUL_LAT must be at least 1.
module hls_mul_share_sched
  import hls_sched_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int MUL_LAT = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  input  logic signed [DW-1:0] c,
  input  logic signed [DW-1:0] d,
  input  logic signed [DW-1:0] e,
  input  logic signed [DW-1:0] f,
  input  logic signed [DW-1:0] g,
  input  logic signed [DW-1:0] h,
  output logic                 Busy,
  output logic                 Done,
  output logic signed [DW-1:0] i,
  output logic signed [DW-1:0] j,
  output logic signed [DW-1:0] k,
  output logic signed [DW-1:0] l
);

  state_t               state;
  op_idx_t              issue_cnt;
  logic signed [DW-1:0] bank_x [NUM_OPS];
  logic signed [DW-1:0] bank_y [NUM_OPS];

  logic                 mul_in_vld;
  logic signed [DW-1:0] mul_x;
  logic signed [DW-1:0] mul_y;
  logic                 mul_out_vld;
  op_idx_t              mul_out_tag;
  logic signed [DW-1:0] mul_p;

  logic                 accept;
  logic                 last_retire;

  assign accept      = (state == IDLE) && Start;
  assign last_retire = mul_out_vld && (mul_out_tag == LAST_OP);

  // Exactly one issue per cycle while in ISSUE; the issue counter is also the tag.
  assign mul_in_vld = (state == ISSUE);
  assign mul_x      = bank_x[issue_cnt];
  assign mul_y      = bank_y[issue_cnt];

  shared_mul_pipe #(
    .DW      (DW),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .Clk     (Clk),
    .Rst     (Rst),
    .in_vld  (mul_in_vld),
    .in_tag  (issue_cnt),
    .x       (mul_x),
    .y       (mul_y),
    .out_vld (mul_out_vld),
    .out_tag (mul_out_tag),
    .p       (mul_p)
  );

  // Control FSM: accept in IDLE, four issues, then wait for the last retirement.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            state     <= ISSUE;
            issue_cnt <= '0;
            Busy      <= 1'b1;
          end
        end
        ISSUE: begin
          issue_cnt <= issue_cnt + 1'b1;
          if (issue_cnt == LAST_OP) state <= DRAIN;
        end
        DRAIN: begin
          if (last_retire) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand bank: captured only on the accept edge, so later input changes
  // and Starts that arrive while busy leave it untouched.
  always_ff @(posedge Clk) begin
    if (!Rst && accept) begin
      bank_x[0] <= a;  bank_y[0] <= b;
      bank_x[1] <= c;  bank_y[1] <= d;
      bank_x[2] <= e;  bank_y[2] <= f;
      bank_x[3] <= g;  bank_y[3] <= h;
    end
  end

  // Result registers, routed by the tag returning from the multiplier; each
  // one holds its value until its own product retires.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      i <= '0;
      j <= '0;
      k <= '0;
      l <= '0;
    end else if (mul_out_vld) begin
      case (mul_out_tag)
        2'd0: i <= mul_p;
        2'd1: j <= mul_p;
        2'd2: k <= mul_p;
        2'd3: l <= mul_p;
      endcase
    end
  end

endmodule

// File: tb/tb_hls_mul_share_sched.sv
// Bench for hls_mul_share_sched: three instances (MUL_LAT = 1, 2, 4) share
// the same stimulus. A transaction-level reference model predicts, from the
// accept cycle and the retire-time rule, every output of every instance.
module tb_hls_mul_share_sched;

  localparam int DW = 16;
  localparam int NI = 3;
  localparam int LATS [NI] = '{1, 2, 4};

  logic                 Clk = 1'b0;
  logic                 Rst;
  logic                 Start;
  logic signed [DW-1:0] a, b, c, d, e, f, g, h;

  logic [NI-1:0]        busy;
  logic [NI-1:0]        done;
  logic signed [DW-1:0] res_i [NI];
  logic signed [DW-1:0] res_j [NI];
  logic signed [DW-1:0] res_k [NI];
  logic signed [DW-1:0] res_l [NI];

  int vectors    = 0;
  int miscompares = 0;
  bit mon_en     = 1'b0;

  always #5 Clk = ~Clk;

  for (genvar m = 0; m < NI; m++) begin : g_dut
    hls_mul_share_sched #(
      .DW      (DW),
      .MUL_LAT (LATS[m])
    ) u_dut (
      .Clk   (Clk),
      .Rst   (Rst),
      .Start (Start),
      .a     (a),
      .b     (b),
      .c     (c),
      .d     (d),
      .e     (e),
      .f     (f),
      .g     (g),
      .h     (h),
      .Busy  (busy[m]),
      .Done  (done[m]),
      .i     (res_i[m]),
      .j     (res_j[m]),
      .k     (res_k[m]),
      .l     (res_l[m])
    );
  end

  // ---------------------------------------------------------------------
  // Reference model: a transaction is accepted when idle and Start is seen;
  // product n lands at accept + 1 + n + MUL_LAT; the last one ends the job.
  // ---------------------------------------------------------------------
  int                   cyc = 0;
  bit                   m_busy [NI];
  bit                   m_done [NI];
  int                   m_acc  [NI];
  logic signed [DW-1:0] m_op   [NI][8];
  logic signed [DW-1:0] m_out  [NI][4];

  function automatic logic signed [DW-1:0] mul_trunc(input logic signed [DW-1:0] x,
                                                     input logic signed [DW-1:0] y);
    logic signed [2*DW-1:0] full;
    full = x * y;
    return full[DW-1:0];
  endfunction

  always @(posedge Clk) begin
    cyc++;
    for (int m = 0; m < NI; m++) begin
      if (Rst) begin
        m_busy[m] = 1'b0;
        m_done[m] = 1'b0;
        for (int n = 0; n < 4; n++) m_out[m][n] = '0;
      end else begin
        m_done[m] = 1'b0;
        if (m_busy[m]) begin
          for (int n = 0; n < 4; n++) begin
            if (cyc == m_acc[m] + 1 + n + LATS[m]) begin
              m_out[m][n] = mul_trunc(m_op[m][2*n], m_op[m][2*n+1]);
              if (n == 3) begin
                m_done[m] = 1'b1;
                m_busy[m] = 1'b0;
              end
            end
          end
        end else if (Start) begin
          m_busy[m] = 1'b1;
          m_acc[m]  = cyc;
          m_op[m]   = '{a, b, c, d, e, f, g, h};
        end
      end
    end
  end

  // Cycle-by-cycle scoreboard, sampled on the falling edge.
  always @(negedge Clk) begin
    if (mon_en) begin
      for (int m = 0; m < NI; m++) begin
        vectors++;
        if (busy[m] !== m_busy[m] || done[m] !== m_done[m] ||
            res_i[m] !== m_out[m][0] || res_j[m] !== m_out[m][1] ||
            res_k[m] !== m_out[m][2] || res_l[m] !== m_out[m][3]) begin
          miscompares++;
          $display("FAIL scoreboard lat=%0d cyc=%0d: got busy=%b done=%b i=%0d j=%0d k=%0d l=%0d, want busy=%b done=%b i=%0d j=%0d k=%0d l=%0d",
                   LATS[m], cyc, busy[m], done[m], res_i[m], res_j[m], res_k[m], res_l[m],
                   m_busy[m], m_done[m], m_out[m][0], m_out[m][1], m_out[m][2], m_out[m][3]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic set_ops(input logic signed [DW-1:0] ops [8]);
    a = ops[0]; b = ops[1]; c = ops[2]; d = ops[3];
    e = ops[4]; f = ops[5]; g = ops[6]; h = ops[7];
  endtask

  task automatic rand_ops();
    a = DW'($urandom); b = DW'($urandom); c = DW'($urandom); d = DW'($urandom);
    e = DW'($urandom); f = DW'($urandom); g = DW'($urandom); h = DW'($urandom);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
  endtask

  // Runs one fixed-operand job, checks Done latency per instance and the results.
  task automatic run_fixed(input string name,
                           input logic signed [DW-1:0] ops [8],
                           input int exp_res [4]);
    int seen [NI];
    int got  [4];
    for (int m = 0; m < NI; m++) seen[m] = -1;
    set_ops(ops);
    pulse_start();
    rand_ops();
    for (int cy = 1; cy <= 20; cy++) begin
      tick(1);
      for (int m = 0; m < NI; m++)
        if (done[m] === 1'b1 && seen[m] < 0) seen[m] = cy;
    end
    for (int m = 0; m < NI; m++) begin
      vectors++;
      if (seen[m] !== 4 + LATS[m]) begin
        miscompares++;
        $display("FAIL %s_latency lat=%0d: Done after %0d cycles (-1 = timeout), want %0d",
                 name, LATS[m], seen[m], 4 + LATS[m]);
      end
      got = '{int'(res_i[m]), int'(res_j[m]), int'(res_k[m]), int'(res_l[m])};
      for (int n = 0; n < 4; n++) begin
        vectors++;
        if (got[n] !== exp_res[n]) begin
          miscompares++;
          $display("FAIL %s_result%0d lat=%0d: got %0d, want %0d",
                   name, n, LATS[m], got[n], exp_res[n]);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    Rst   = 1'b1;
    Start = 1'b0;
    rand_ops();
    tick(3);
    Rst    = 1'b0;
    mon_en = 1'b1;
    for (int m = 0; m < NI; m++) begin
      vectors++;
      if (busy[m] !== 1'b0 || done[m] !== 1'b0 || res_i[m] !== '0 ||
          res_j[m] !== '0 || res_k[m] !== '0 || res_l[m] !== '0) begin
        miscompares++;
        $display("FAIL reset lat=%0d: got busy=%b done=%b i=%0d j=%0d k=%0d l=%0d, want all 0",
                 LATS[m], busy[m], done[m], res_i[m], res_j[m], res_k[m], res_l[m]);
      end
    end
    tick(2);
  endtask

  task automatic test_basic();
    logic signed [DW-1:0] ops [8];
    int                   exp_res [4];
    ops     = '{16'sd3, 16'sd4, -16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sd9, 16'sd10};
    exp_res = '{12, -30, 56, 90};
    run_fixed("basic", ops, exp_res);
  endtask

  task automatic test_truncation();
    logic signed [DW-1:0] ops [8];
    int                   exp_res [4];
    ops     = '{-16'sd1, -16'sd1, 16'sd123, -16'sd45, 16'sd300, 16'sd300, -16'sd32768, -16'sd1};
    exp_res = '{1, -5535, 24464, -32768};
    run_fixed("trunc", ops, exp_res);
  endtask

  task automatic test_busy_ignore();
    logic signed [DW-1:0] first [8];
    int                   pulses [NI];
    logic signed [DW-1:0] want;
    rand_ops();
    first = '{a, b, c, d, e, f, g, h};
    pulse_start();
    tick(1);
    rand_ops();
    pulse_start();
    rand_ops();
    for (int m = 0; m < NI; m++) pulses[m] = 0;
    for (int cy = 0; cy < 16; cy++) begin
      tick(1);
      for (int m = 0; m < NI; m++) if (done[m] === 1'b1) pulses[m]++;
    end
    for (int m = 0; m < NI; m++) begin
      vectors++;
      if (pulses[m] != 1) begin
        miscompares++;
        $display("FAIL busy_ignore_pulses lat=%0d: got %0d Done pulses, want 1", LATS[m], pulses[m]);
      end
      want = mul_trunc(first[6], first[7]);
      vectors++;
      if (res_l[m] !== want) begin
        miscompares++;
        $display("FAIL busy_ignore_l lat=%0d: got %0d, want %0d", LATS[m], res_l[m], want);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit prev_low [NI];
    int gaps     [NI];
    int pulses   [NI];
    for (int m = 0; m < NI; m++) begin
      prev_low[m] = 1'b0;
      gaps[m]     = 0;
      pulses[m]   = 0;
    end
    Start = 1'b1;
    rand_ops();
    tick(1);
    for (int cy = 0; cy < 40; cy++) begin
      rand_ops();
      tick(1);
      for (int m = 0; m < NI; m++) begin
        if (busy[m] !== 1'b1 && prev_low[m]) gaps[m]++;
        prev_low[m] = (busy[m] !== 1'b1);
        if (done[m] === 1'b1) pulses[m]++;
      end
    end
    Start = 1'b0;
    tick(12);
    for (int m = 0; m < NI; m++) begin
      vectors++;
      if (gaps[m] != 0 || pulses[m] < 3) begin
        miscompares++;
        $display("FAIL back_to_back lat=%0d: got %0d multi-cycle idle gaps and %0d Done pulses, want 0 gaps and >=3 pulses",
                 LATS[m], gaps[m], pulses[m]);
      end
    end
  endtask

  task automatic test_reset_mid();
    rand_ops();
    pulse_start();
    tick(2);
    Rst = 1'b1;
    tick(1);
    Rst = 1'b0;
    for (int cy = 0; cy < 8; cy++) begin
      tick(1);
      for (int m = 0; m < NI; m++) begin
        vectors++;
        if (busy[m] !== 1'b0 || done[m] !== 1'b0 || res_i[m] !== '0 ||
            res_j[m] !== '0 || res_k[m] !== '0 || res_l[m] !== '0) begin
          miscompares++;
          $display("FAIL reset_mid lat=%0d cy=%0d: got busy=%b done=%b i=%0d j=%0d k=%0d l=%0d, want all 0",
                   LATS[m], cy, busy[m], done[m], res_i[m], res_j[m], res_k[m], res_l[m]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      rand_ops();
      Start = 1'b1;
      tick($urandom_range(1, 3));
      Start = 1'b0;
      for (int w = $urandom_range(0, 12); w > 0; w--) begin
        if ($urandom_range(0, 3) == 0) rand_ops();
        Start = ($urandom_range(0, 4) == 0);
        tick(1);
      end
      Start = 1'b0;
      if ($urandom_range(0, 14) == 0) begin
        Rst = 1'b1;
        tick(1);
        Rst = 1'b0;
      end
    end
    tick(12);
  endtask

  initial begin
    Rst   = 1'b1;
    Start = 1'b0;
    test_reset();
    test_basic();
    test_truncation();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
